// File: rtl/chunk_adder_if.sv
`default_nettype none
// ============================================================================
// Module      : chunk_adder_if
// Description : Request/result bundle for the multi-cycle chunked adder.
//               master drives start/a/b/cin/sub and observes busy/done/sum/cout;
//               slave is the adder side.
// Ports       : start, a[WIDTH], b[WIDTH], cin, sub  (master -> slave)
//               busy, done, sum[WIDTH], cout         (slave -> master)
// Revision    : 1.0 - initial release
// ============================================================================
interface chunk_adder_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport master (
    output start, a, b, cin, sub,
    input  busy, done, sum, cout
  );

  modport slave (
    input  start, a, b, cin, sub,
    output busy, done, sum, cout
  );
endinterface
`default_nettype wire

// File: rtl/chunk_adder.sv
`default_nettype none
// ============================================================================
// Module      : chunk_adder
// Description : Serial-by-chunk adder/subtractor. Adds CHUNK bits per clock,
//               LSB chunk first, producing a WIDTH-bit result after
//               N = WIDTH/CHUNK RUN cycles. Subtraction is A + ~B + 1, so in
//               sub mode cout = 1 means no borrow (A >= B).
// Ports       : clk    - rising-edge clock
//               rst_n  - asynchronous active-low reset
//               bus    - chunk_adder_if.slave (start/a/b/cin/sub in,
//                        busy/done/sum/cout out)
// Revision    : 1.0 - initial release
// ============================================================================
module chunk_adder #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  wire          clk,
  input  wire          rst_n,
  chunk_adder_if.slave bus
);

  localparam int N  = WIDTH / CHUNK;
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  localparam logic [IW-1:0] c_LAST = IW'(N - 1);

  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_RUN  = 2'd1;
  localparam logic [1:0] c_DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;

  // Current chunk operands and their CHUNK+1 bit sum (top bit = chunk carry)
  logic [CHUNK-1:0] w_chunk_a;
  logic [CHUNK-1:0] w_chunk_b;
  logic [CHUNK:0]   w_chunk_sum;

  assign w_chunk_a   = a_q[int'(idx_q) * CHUNK +: CHUNK];
  assign w_chunk_b   = b_q[int'(idx_q) * CHUNK +: CHUNK];
  assign w_chunk_sum = {1'b0, w_chunk_a} + {1'b0, w_chunk_b} + {{CHUNK{1'b0}}, carry_q};

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    acc_d   = acc_q;
    sum_d   = sum_q;
    cout_d  = cout_q;

    case (state_q)
      // DONE accepts a new start exactly like IDLE, giving back-to-back ops
      c_IDLE, c_DONE: begin
        if (bus.start) begin
          a_d     = bus.a;
          b_d     = bus.sub ? ~bus.b : bus.b;
          carry_d = bus.sub ? 1'b1 : bus.cin;
          idx_d   = '0;
          state_d = c_RUN;
        end else begin
          state_d = c_IDLE;
        end
      end

      c_RUN: begin
        acc_d[int'(idx_q) * CHUNK +: CHUNK] = w_chunk_sum[CHUNK-1:0];
        carry_d = w_chunk_sum[CHUNK];
        if (idx_q == c_LAST) begin
          // acc_d already holds the final chunk written above
          sum_d   = acc_d;
          cout_d  = w_chunk_sum[CHUNK];
          state_d = c_DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end

      default: state_d = c_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= c_IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      acc_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      acc_q   <= acc_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

  assign bus.busy = (state_q == c_RUN);
  assign bus.done = (state_q == c_DONE);
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;

endmodule
`default_nettype wire

// File: tb/tb_chunk_adder.sv
`default_nettype none
// ============================================================================
// Module      : tb_chunk_adder
// Description : Self-checking bench for chunk_adder (WIDTH=32, CHUNK=8).
//               Directed and random operations are compared against an
//               arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_chunk_adder;

  localparam int WIDTH = 32;
  localparam int CHUNK = 8;
  localparam int N     = WIDTH / CHUNK;

  logic clk;
  logic rst_n;

  int n_checks;
  int n_errors;

  logic [WIDTH-1:0] prev_sum;
  logic             prev_cout;

  chunk_adder_if #(.WIDTH(WIDTH)) bus ();

  chunk_adder #(
    .WIDTH(WIDTH),
    .CHUNK(CHUNK)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic, {cout, sum}
  function automatic logic [WIDTH:0] model(input logic [WIDTH-1:0] ma, mb,
                                           input logic mc, ms);
    logic [WIDTH:0] r;
    if (ms) begin
      r[WIDTH-1:0] = ma - mb;
      r[WIDTH]     = (ma >= mb);
    end else begin
      r = {1'b0, ma} + {1'b0, mb} + {{WIDTH{1'b0}}, mc};
    end
    return r;
  endfunction

  // Entry: at a negedge where the DUT will accept start on the next edge.
  // Exit: at the negedge right after the done edge (chain=1), or one cycle
  // later with the DUT back in IDLE (chain=0).
  task automatic run_op(input logic [WIDTH-1:0] oa, ob, input logic oc, os,
                        input bit glitch, input bit chain,
                        input logic [WIDTH-1:0] na, nb);
    logic [WIDTH:0] exp;
    exp = model(oa, ob, oc, os);
    bus.start = 1'b1;
    bus.a = oa; bus.b = ob; bus.cin = oc; bus.sub = os;
    @(negedge clk);
    bus.start = 1'b0;
    if (glitch) begin
      bus.a = $urandom; bus.b = $urandom;
      bus.cin = 1'($urandom); bus.sub = 1'($urandom);
    end
    for (int i = 0; i < N; i++) begin
      check("busy_run", bus.busy, 1);
      check("done_run", bus.done, 0);
      check("sum_hold", bus.sum, prev_sum);
      check("cout_hold", bus.cout, prev_cout);
      if (glitch && i == 1) begin
        bus.start = 1'b1;
        bus.a = $urandom; bus.b = $urandom;
        bus.cin = 1'($urandom); bus.sub = 1'($urandom);
      end
      if (glitch && i == 2) bus.start = 1'b0;
      if (chain && i == N - 1) begin
        bus.start = 1'b1;
        bus.a = na; bus.b = nb; bus.cin = 1'b0; bus.sub = 1'b0;
      end
      @(negedge clk);
    end
    check("done_pulse", bus.done, 1);
    check("busy_done", bus.busy, 0);
    check("sum", bus.sum, exp[WIDTH-1:0]);
    check("cout", bus.cout, exp[WIDTH]);
    prev_sum  = exp[WIDTH-1:0];
    prev_cout = exp[WIDTH];
    if (!chain) begin
      bus.start = 1'b0;
      @(negedge clk);
      check("no_extra_done", bus.done, 0);
      check("busy_idle", bus.busy, 0);
    end
  endtask

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    prev_sum  = '0;
    prev_cout = 1'b0;
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.a = '0; bus.b = '0; bus.cin = 1'b0; bus.sub = 1'b0;

    #2;
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_sum", bus.sum, 0);
    check("rst_cout", bus.cout, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed cases
    run_op(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
    run_op(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
    run_op(32'd5, 32'd7, 1'b0, 1'b1, 1'b0, 1'b0, '0, '0);
    run_op(32'd7, 32'd5, 1'b0, 1'b1, 1'b0, 1'b0, '0, '0);
    run_op(32'h1234_5678, 32'h1234_5678, 1'b0, 1'b1, 1'b0, 1'b0, '0, '0);

    // Back-to-back: second op latched from DONE with no idle cycle
    run_op(32'hDEAD_BEEF, 32'h0101_0101, 1'b1, 1'b0, 1'b0, 1'b1,
           32'h1234_5678, 32'h1111_1111);
    run_op(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
    check("b2b_sum", bus.sum, 32'h2345_6789);

    // Start ignored and operand changes mid-RUN
    run_op(32'hCAFE_0001, 32'h0000_FFFF, 1'b0, 1'b0, 1'b1, 1'b0, '0, '0);

    // Reset on the second RUN cycle
    bus.start = 1'b1;
    bus.a = 32'h0F0F_0F0F; bus.b = 32'h1111_1111; bus.cin = 1'b0; bus.sub = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_busy", bus.busy, 0);
    check("abort_done", bus.done, 0);
    check("abort_sum", bus.sum, 0);
    check("abort_cout", bus.cout, 0);
    prev_sum  = '0;
    prev_cout = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < N + 2; i++) begin
      @(negedge clk);
      check("abort_no_done", bus.done, 0);
      check("abort_idle", bus.busy, 0);
    end
    run_op(32'h0F0F_0F0F, 32'h1111_1111, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0);

    // Random operations
    for (int k = 0; k < 30; k++) begin
      logic [WIDTH-1:0] ra, rb;
      logic rc, rs;
      ra = $urandom;
      rb = (k % 7 == 0) ? ra : $urandom;
      rc = 1'($urandom);
      rs = 1'($urandom);
      run_op(ra, rb, rc, rs, bit'($urandom_range(0, 1)), 1'b0, '0, '0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/chunk_adder.md
CHUNK_ADDER -- requirements
Module: chunk_adder

Interface
REQ-001: Parameter WIDTH, default 32, operand and result width in bits.
REQ-002: Parameter CHUNK, default 8, bits added per clock; WIDTH SHALL be an integer multiple of CHUNK; N = WIDTH/CHUNK.
REQ-003: clk  input  1  single clock, all state updates on rising edge.
REQ-004: rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005: start  input  1  request a new operation; sampled on rising edge.
REQ-006: a  input  WIDTH  operand A, unsigned.
REQ-007: b  input  WIDTH  operand B, unsigned.
REQ-008: cin  input  1  carry-in for add mode.
REQ-009: sub  input  1  mode select: 0 = A+B+cin, 1 = A-B.
REQ-010: busy  output  1  high while an operation is in progress.
REQ-011: done  output  1  one-cycle pulse marking a valid result.
REQ-012: sum  output  WIDTH  registered result.
REQ-013: cout  output  1  registered carry-out; in sub mode, 1 = no borrow (A >= B).

Function
REQ-014: Three states SHALL exist: IDLE, RUN and DONE.
REQ-015: IDLE with start=1 at an edge: latch a, b, cin and sub; clear chunk index to 0; go to RUN.
REQ-016: Latched B SHALL be ~b when sub=1; latched carry SHALL be 1 when sub=1 and cin otherwise.
REQ-017: RUN: each edge adds chunk i of A, chunk i of B and the running carry, LSB chunk first; writes the CHUNK-bit result into internal accumulator bits; stores the chunk carry-out as the running carry; increments i.
REQ-018: After chunk N-1 is processed, the FSM SHALL copy the accumulator to sum and the final carry to cout, then enter DONE.
REQ-019: Latency: start sampled at edge k leads to done=1 and valid sum/cout after edge k+N.
REQ-020: DONE lasts one cycle; done=1 and busy=0 in DONE only; busy=1 in RUN only.
REQ-021: DONE with start=1: operands latched, go to RUN (back-to-back, no idle cycle); start=0: go to IDLE.
REQ-022: start in RUN SHALL be ignored; latched operands are not disturbed by input changes after the start edge.
REQ-023: sum and cout SHALL change only on the transition into DONE and hold otherwise, including across later RUN cycles.
REQ-024: Chunk index wraps never; it counts 0..N-1 only; N=1 SHALL complete in one RUN cycle.
REQ-025: Sum arithmetic is modulo 2^WIDTH; overflow is reported only through cout.

Reset
REQ-026: rst_n=0 SHALL immediately force state IDLE, busy=0, done=0, sum=0, cout=0, chunk index 0, accumulator 0, running carry 0.
REQ-027: Reset asserted during RUN SHALL abort the operation; no done pulse for it after release.
REQ-028: First start accepted at the first rising edge with rst_n=1.

Verification (WIDTH=32, CHUNK=8, N=4)
REQ-029: Add: a=0x0000_00FF, b=0x0000_0001, cin=0, start one cycle -> busy high 4 cycles, then done pulse with sum=0x0000_0100, cout=0.
REQ-030: Overflow: a=0xFFFF_FFFF, b=0x0000_0000, cin=1 -> sum=0x0000_0000, cout=1 after 4 cycles.
REQ-031: Subtract: sub=1, a=5, b=7 -> sum=0xFFFF_FFFE, cout=0; sub=1, a=7, b=5 -> sum=2, cout=1.
REQ-032: Back-to-back: start held high across DONE with new operands 0x1234_5678 + 0x1111_1111 -> second done exactly 5 cycles after the first, sum=0x2345_6789; earlier sum holds until then.
REQ-033: Start ignored and input stability: pulse start again and change a/b mid-RUN -> result equals the originally latched operands; no extra done.
REQ-034: Reset mid-op: assert rst_n=0 on the 2nd RUN cycle -> outputs zero at once; no done after release; next start completes normally.
